// File: rtl/walksat_step_controller_if.sv
// -----------------------------------------------------------------------------
// walksat_step_controller_if
// Handshake and control-bus bundle between the WalkSAT step controller and its
// environment (clause selector, variable table, clause/variable/FIFO datapath).
//
// Signals:
//   start            run request (environment -> controller)
//   max_flips        flip budget, 0 = unlimited (environment -> controller)
//   ucs_valid        unsat-clause selector response valid
//   unsat_empty      with ucs_valid: no unsat clause remains
//   control_signal_o datapath control bus (controller -> datapath)
//   lit_idx          literal index being read/evaluated
//   flip_count       flips completed in the current run
//   busy / done      activity flag / one-cycle completion pulse
//   sat_found        run result, valid from done
//   timeout_err      SELECT watchdog fired
//
// Modports: master = controller side, slave = environment side.
// -----------------------------------------------------------------------------
interface walksat_step_controller_if #(
  parameter int K      = 3,
  parameter int FLIP_W = 16,
  parameter int CTRL_W = 14
);
  localparam int LIT_W = (K > 1) ? $clog2(K) : 1;

  logic              start;
  logic [FLIP_W-1:0] max_flips;
  logic              ucs_valid;
  logic              unsat_empty;
  logic [CTRL_W-1:0] control_signal_o;
  logic [LIT_W-1:0]  lit_idx;
  logic [FLIP_W-1:0] flip_count;
  logic              busy;
  logic              done;
  logic              sat_found;
  logic              timeout_err;

  modport master (
    input  start, max_flips, ucs_valid, unsat_empty,
    output control_signal_o, lit_idx, flip_count, busy, done, sat_found,
           timeout_err
  );

  modport slave (
    output start, max_flips, ucs_valid, unsat_empty,
    input  control_signal_o, lit_idx, flip_count, busy, done, sat_found,
           timeout_err
  );
endinterface

// File: rtl/walksat_step_controller.sv
// -----------------------------------------------------------------------------
// walksat_step_controller
// Sequences one WalkSAT flip per iteration: select an unsat clause, read its K
// literals from the variable table, evaluate/count/gather, flip the chosen
// variable. Loops until the selector reports no unsat clause (SAT) or the flip
// budget is spent.
//
// Ports:
//   clk  - system clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - walksat_step_controller_if.master (handshake + control bus)
//
// Optional build macro WSC_TIMEOUT_EN: adds a SELECT watchdog of TIMEOUT cycles
// that ends the run with timeout_err=1. Without it SELECT waits forever and
// timeout_err is tied low.
//
// control_signal_o is a registered decode of the next state, so the bits for
// a state are present during the first cycle spent in that state.
// -----------------------------------------------------------------------------
module walksat_step_controller #(
  parameter int K       = 3,
  parameter int FLIP_W  = 16,
  parameter int VT_LAT  = 1,
  parameter int CTRL_W  = 14,
  parameter int TIMEOUT = 255
) (
  input  logic                       clk,
  input  logic                       rst,
  walksat_step_controller_if.master  bus
);
  localparam int LIT_W   = (K > 1) ? $clog2(K) : 1;
  localparam int DWELL_W = (VT_LAT > 1) ? $clog2(VT_LAT) : 1;

  // Fixed control words (bit map: [13] CR_WR_EN, [12:11] ATT_SRC,
  // [10] VT_ADDR_SRC, [9] VT_EN, [8] VT_WR_EN, [7:6] VFS_WR_EN,
  // [5] CFLB_WR_EN, [4:3] TB_WR_INDEX, [2] FIFO_WR_EN, [1] FIFO_RD_EN,
  // [0] UCS_REQUEST)
  localparam logic [CTRL_W-1:0] C_SELECT   = CTRL_W'(14'b10000000000001);
  localparam logic [CTRL_W-1:0] C_READ_VAR = CTRL_W'(14'b00001000001000);
  localparam logic [CTRL_W-1:0] C_EVAL     = CTRL_W'(14'b00000001110000);
  localparam logic [CTRL_W-1:0] C_GATHER   = CTRL_W'(14'b00000000000100);
  localparam logic [CTRL_W-1:0] C_SEL_AGN  = CTRL_W'(14'b00000000000010);
  localparam logic [CTRL_W-1:0] C_FLIP     = CTRL_W'(14'b00011100000000);

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD, S_SELECT, S_READ_CLAUSE, S_READ_VAR, S_EVAL,
    S_COUNT, S_GATHER, S_SELECT_AGAIN, S_FLIP, S_DONE
  } state_t;

  state_t              r_state;
  logic [CTRL_W-1:0]   r_ctrl;
  logic [LIT_W-1:0]    r_lit;
  logic [DWELL_W-1:0]  r_dwell;
  logic [FLIP_W-1:0]   r_flips;
  logic [FLIP_W-1:0]   r_budget;
  logic                r_sat;
  logic                r_busy;
  logic                r_done;

  state_t              w_state_nxt;
  logic [LIT_W-1:0]    w_lit_nxt;
  logic [DWELL_W-1:0]  w_dwell_nxt;
  logic [FLIP_W-1:0]   w_flips_nxt;
  logic [FLIP_W-1:0]   w_budget_nxt;
  logic [FLIP_W-1:0]   w_flip_inc;
  logic                w_sat_nxt;
  logic                w_sel_expired;

  // Control word for a state; READ_VAR carries the literal slot on ATT_SRC.
  function automatic logic [CTRL_W-1:0] f_ctrl(input state_t s,
                                               input logic [LIT_W-1:0] lit);
    logic [1:0] att;
    att = 2'(lit);
    case (s)
      S_SELECT:       f_ctrl = C_SELECT;
      S_READ_VAR:     f_ctrl = C_READ_VAR | CTRL_W'({att, 11'b0});
      S_EVAL:         f_ctrl = C_EVAL;
      S_GATHER:       f_ctrl = C_GATHER;
      S_SELECT_AGAIN: f_ctrl = C_SEL_AGN;
      S_FLIP:         f_ctrl = C_FLIP;
      default:        f_ctrl = {CTRL_W{1'b0}};
    endcase
  endfunction

`ifdef WSC_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  logic [TMO_W-1:0] r_sel_cnt;
  logic             r_tmo;

  // Counts cycles spent waiting in SELECT; last waiting cycle is TIMEOUT-1.
  assign w_sel_expired = (r_sel_cnt == TMO_W'(TIMEOUT - 1));

  // SELECT watchdog counter and sticky timeout flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sel_cnt <= {TMO_W{1'b0}};
      r_tmo     <= 1'b0;
    end else begin
      if (r_state == S_SELECT && w_state_nxt == S_SELECT) begin
        r_sel_cnt <= r_sel_cnt + TMO_W'(1);
      end else begin
        r_sel_cnt <= {TMO_W{1'b0}};
      end
      if (r_state == S_IDLE && bus.start) begin
        r_tmo <= 1'b0;
      end else if (r_state == S_SELECT && !bus.ucs_valid && w_sel_expired) begin
        r_tmo <= 1'b1;
      end else begin
        r_tmo <= r_tmo;
      end
    end
  end

  assign bus.timeout_err = r_tmo;
`else
  assign w_sel_expired   = 1'b0;
  // TIMEOUT only matters when the watchdog is built in.
  assign bus.timeout_err = 1'b0 & (TIMEOUT != 0);
`endif

  // Next-state and datapath-register logic.
  always_comb begin
    w_state_nxt  = r_state;
    w_lit_nxt    = r_lit;
    w_dwell_nxt  = r_dwell;
    w_flips_nxt  = r_flips;
    w_budget_nxt = r_budget;
    w_sat_nxt    = r_sat;
    // Saturating increment keeps the counter pinned at all-ones.
    if (&r_flips) begin
      w_flip_inc = r_flips;
    end else begin
      w_flip_inc = r_flips + FLIP_W'(1);
    end
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_state_nxt = S_LOAD;
          w_flips_nxt = {FLIP_W{1'b0}};
          w_sat_nxt   = 1'b0;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_LOAD: begin
        w_budget_nxt = bus.max_flips;
        w_state_nxt  = S_SELECT;
      end
      S_SELECT: begin
        if (bus.ucs_valid) begin
          if (bus.unsat_empty) begin
            w_state_nxt = S_DONE;
            w_sat_nxt   = 1'b1;
          end else begin
            // Literal walk restarts as the clause is entered.
            w_state_nxt = S_READ_CLAUSE;
            w_lit_nxt   = {LIT_W{1'b0}};
            w_dwell_nxt = {DWELL_W{1'b0}};
          end
        end else if (w_sel_expired) begin
          w_state_nxt = S_DONE;
          w_sat_nxt   = 1'b0;
        end else begin
          w_state_nxt = S_SELECT;
        end
      end
      S_READ_CLAUSE: begin
        w_state_nxt = S_READ_VAR;
      end
      S_READ_VAR: begin
        // Each literal is held for VT_LAT cycles to cover table latency.
        if (r_dwell == DWELL_W'(VT_LAT - 1)) begin
          w_dwell_nxt = {DWELL_W{1'b0}};
          if (r_lit == LIT_W'(K - 1)) begin
            w_state_nxt = S_EVAL;
          end else begin
            w_lit_nxt   = r_lit + LIT_W'(1);
          end
        end else begin
          w_dwell_nxt = r_dwell + DWELL_W'(1);
        end
      end
      S_EVAL:         w_state_nxt = S_COUNT;
      S_COUNT:        w_state_nxt = S_GATHER;
      S_GATHER:       w_state_nxt = S_SELECT_AGAIN;
      S_SELECT_AGAIN: w_state_nxt = S_FLIP;
      S_FLIP: begin
        w_flips_nxt = w_flip_inc;
        if (r_budget != {FLIP_W{1'b0}} && w_flip_inc == r_budget) begin
          w_state_nxt = S_DONE;
          w_sat_nxt   = 1'b0;
        end else begin
          w_state_nxt = S_SELECT;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register with registered outputs decoded from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_ctrl   <= {CTRL_W{1'b0}};
      r_lit    <= {LIT_W{1'b0}};
      r_dwell  <= {DWELL_W{1'b0}};
      r_flips  <= {FLIP_W{1'b0}};
      r_budget <= {FLIP_W{1'b0}};
      r_sat    <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_ctrl   <= f_ctrl(w_state_nxt, w_lit_nxt);
      r_lit    <= w_lit_nxt;
      r_dwell  <= w_dwell_nxt;
      r_flips  <= w_flips_nxt;
      r_budget <= w_budget_nxt;
      r_sat    <= w_sat_nxt;
      r_busy   <= (w_state_nxt != S_IDLE);
      r_done   <= (w_state_nxt == S_DONE);
    end
  end

  assign bus.control_signal_o = r_ctrl;
  assign bus.lit_idx          = r_lit;
  assign bus.flip_count       = r_flips;
  assign bus.busy             = r_busy;
  assign bus.done             = r_done;
  assign bus.sat_found        = r_sat;
endmodule

// File: tb/tb_walksat_step_controller.sv
// -----------------------------------------------------------------------------
// tb_walksat_step_controller
// Builds a cycle-by-cycle plan of runs from the controller's rules (phase list
// per iteration, plain arithmetic on counts). Each planned cycle carries the
// inputs to drive and the outputs the controller must show in that cycle. The
// driver issues inputs and pushes the expected outputs into a scoreboard queue;
// an independent monitor pops and compares on the falling edge.
// -----------------------------------------------------------------------------
module tb_walksat_step_controller;
  localparam int K       = 5;
  localparam int VT_LAT  = 2;
  localparam int FLIP_W  = 16;
  localparam int CTRL_W  = 14;
  localparam int TIMEOUT = 8;
  localparam int LIT_W   = (K > 1) ? $clog2(K) : 1;
`ifdef WSC_TIMEOUT_EN
  localparam int LONG_STALL = TIMEOUT - 1;
`else
  localparam int LONG_STALL = 20;
`endif

  localparam int W_SELECT = 14'b10000000000001;
  localparam int W_EVAL   = 14'b00000001110000;
  localparam int W_GATHER = 14'b00000000000100;
  localparam int W_SELAGN = 14'b00000000000010;
  localparam int W_FLIP   = 14'b00011100000000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  walksat_step_controller_if #(.K(K), .FLIP_W(FLIP_W), .CTRL_W(CTRL_W)) bus ();

  walksat_step_controller #(
    .K(K), .FLIP_W(FLIP_W), .VT_LAT(VT_LAT), .CTRL_W(CTRL_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.master)
  );

  typedef struct packed {
    logic              rst;
    logic              start;
    logic [FLIP_W-1:0] mf;
    logic              uv;
    logic              ue;
    logic [CTRL_W-1:0] ctrl;
    logic [LIT_W-1:0]  lit;
    logic [FLIP_W-1:0] fc;
    logic              busy;
    logic              done;
    logic              sat;
    logic              tmo;
  } ent_t;

  ent_t plan_q[$];
  ent_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference-model sticky outputs.
  int m_lit = 0;
  int m_fc  = 0;
  bit m_sat = 1'b0;
  bit m_tmo = 1'b0;

  function automatic int rv_word(int l);
    return (1 << 9) | (1 << 3) | ((l % 4) << 11);
  endfunction

  task automatic emit(bit r, bit st, int mf, bit uv, bit ue, int ctrl,
                      bit busy, bit done);
    ent_t e;
    e.rst   = r;
    e.start = st;
    e.mf    = FLIP_W'(mf);
    e.uv    = uv;
    e.ue    = ue;
    e.ctrl  = CTRL_W'(ctrl);
    e.lit   = LIT_W'(m_lit);
    e.fc    = FLIP_W'(m_fc);
    e.busy  = busy;
    e.done  = done;
    e.sat   = m_sat;
    e.tmo   = m_tmo;
    plan_q.push_back(e);
  endtask

  // Busy cycle outside SELECT: every input is noise the controller must ignore.
  task automatic noisy(int ctrl, bit done);
    emit(1'b0, 1'($urandom), int'($urandom), 1'($urandom), 1'($urandom),
         ctrl, 1'b1, done);
  endtask

  // One run: n_unsat unsat responses before the selector reports SAT.
  task automatic gen_run(int budget, int n_unsat, bit long_stall, bit abort,
                         bit tmo_run);
    int idle;
    int stall;
    int it;
    idle = 1 + int'($urandom % 3);
    for (int i = 0; i < idle; i++)
      emit(1'b0, 1'b0, int'($urandom), 1'($urandom), 1'($urandom), 0, 1'b0, 1'b0);
    emit(1'b0, 1'b1, budget, 1'($urandom), 1'($urandom), 0, 1'b0, 1'b0);
    m_fc = 0; m_sat = 1'b0; m_tmo = 1'b0;
    emit(1'b0, 1'($urandom), budget, 1'($urandom), 1'($urandom), 0, 1'b1, 1'b0);
    it = 0;
    while (1'b1) begin
      if (tmo_run) stall = TIMEOUT;
      else if (long_stall && it == 0) stall = LONG_STALL;
      else stall = int'($urandom % 4);
      for (int s = 0; s < stall; s++)
        emit(1'b0, 1'($urandom), int'($urandom), 1'b0, 1'($urandom),
             W_SELECT, 1'b1, 1'b0);
      if (tmo_run) begin
        m_tmo = 1'b1; m_sat = 1'b0;
        noisy(0, 1'b1);
        return;
      end
      emit(1'b0, 1'($urandom), int'($urandom), 1'b1, (it >= n_unsat),
           W_SELECT, 1'b1, 1'b0);
      if (it >= n_unsat) begin
        m_sat = 1'b1;
        noisy(0, 1'b1);
        return;
      end
      m_lit = 0;
      noisy(0, 1'b0);
      for (int l = 0; l < K; l++) begin
        for (int v = 0; v < VT_LAT; v++) begin
          m_lit = l;
          if (abort) begin
            emit(1'b1, 1'($urandom), int'($urandom), 1'($urandom), 1'($urandom),
                 rv_word(l), 1'b1, 1'b0);
            m_lit = 0; m_fc = 0; m_sat = 1'b0; m_tmo = 1'b0;
            return;
          end
          noisy(rv_word(l), 1'b0);
        end
      end
      noisy(W_EVAL, 1'b0);
      noisy(0, 1'b0);
      noisy(W_GATHER, 1'b0);
      noisy(W_SELAGN, 1'b0);
      noisy(W_FLIP, 1'b0);
      if (m_fc < (1 << FLIP_W) - 1) m_fc = m_fc + 1;
      if (budget != 0 && m_fc == budget) begin
        noisy(0, 1'b1);
        return;
      end
      it++;
    end
  endtask

  // Monitor: compares every cycle's outputs against the scoreboard head.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      ent_t e;
      e = exp_q.pop_front();
      checks++;
      if ({bus.control_signal_o, bus.lit_idx, bus.flip_count, bus.busy,
           bus.done, bus.sat_found, bus.timeout_err} !==
          {e.ctrl, e.lit, e.fc, e.busy, e.done, e.sat, e.tmo}) begin
        failures++;
        $display("FAIL cycle_outputs t=%0t got ctrl=%b lit=%0d fc=%0d busy=%b done=%b sat=%b tmo=%b want ctrl=%b lit=%0d fc=%0d busy=%b done=%b sat=%b tmo=%b",
                 $time, bus.control_signal_o, bus.lit_idx, bus.flip_count,
                 bus.busy, bus.done, bus.sat_found, bus.timeout_err,
                 e.ctrl, e.lit, e.fc, e.busy, e.done, e.sat, e.tmo);
      end
    end
  end

  initial begin
    bus.start       = 1'b0;
    bus.max_flips   = '0;
    bus.ucs_valid   = 1'b0;
    bus.unsat_empty = 1'b0;

    // Reset for 5 cycles with start asserted: reset must win.
    for (int i = 0; i < 5; i++)
      emit(1'b1, 1'b1, int'($urandom), 1'($urandom), 1'($urandom), 0, 1'b0, 1'b0);
    gen_run(0, 0, 1'b0, 1'b0, 1'b0);     // immediate SAT
    gen_run(3, 99, 1'b0, 1'b0, 1'b0);    // budget exhaustion after 3 flips
    gen_run(1, 99, 1'b0, 1'b0, 1'b0);    // single-flip budget
    gen_run(2, 99, 1'b1, 1'b0, 1'b0);    // long SELECT stall
    gen_run(2, 99, 1'b0, 1'b0, 1'b0);    // back-to-back run
    gen_run(2, 99, 1'b0, 1'b1, 1'b0);    // reset during READ_VAR
    gen_run(0, 2, 1'b0, 1'b0, 1'b0);     // SAT after two flips, no budget
`ifdef WSC_TIMEOUT_EN
    gen_run(0, 0, 1'b0, 1'b0, 1'b1);     // watchdog expiry
    gen_run(1, 99, 1'b0, 1'b0, 1'b0);    // next start clears timeout_err
`endif
    for (int r = 0; r < 12; r++)
      gen_run(int'($urandom % 4), int'($urandom % 5), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++)
      emit(1'b0, 1'b0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0);

    // Driver: inputs for each planned cycle, expected outputs to the scoreboard.
    while (plan_q.size() > 0) begin
      ent_t e;
      e = plan_q.pop_front();
      @(posedge clk);
      #1;
      rst             = e.rst;
      bus.start       = e.start;
      bus.max_flips   = e.mf;
      bus.ucs_valid   = e.uv;
      bus.unsat_empty = e.ue;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    rst       = 1'b0;
    bus.start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain pending=%0d want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
